lfsr_rng_gen: RTL and testbench
===============================

// Module: lfsr_rng_gen
// PURPOSE
//  Parametrised Fibonacci-LFSR random-word generator, successor to the fixed 32-bit PRNG.
//  Adds: configurable width/taps/seed, runtime seed load with zero-seed guard, warm-up discard,
//  multi-step advance per word, enable/freeze, and a valid/ready output handshake so
//  consumers (e.g. random index/slot selection) can back-pressure without losing words.
// PARAMETERS
//  LFSR_W         32            LFSR state width (>=8)
//  TAPS           32'hB89ADA1C  feedback mask, bit i set = state bit i in XOR feedback
//  SEED           32'hAAAAAAAA  reset seed; also substituted for an all-zero seed_in (must be nonzero)
//  OUT_W          4             output word width (1..LFSR_W)
//  STEPS          1             LFSR shifts per emitted word (1..LFSR_W, unrolled combinationally)
//  WARMUP_CYCLES  0             single shifts discarded after reset/seed load before first word
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        synchronous active-low reset
//  en            in   1        advance enable; 0 freezes LFSR and warm-up counter
//  seed_load     in   1        1-cycle request to load seed_in
//  seed_in       in   LFSR_W   new seed
//  out_data      out  OUT_W    random word = state[OUT_W-1:0] after word's STEPS shifts
//  out_valid     out  1        out_data valid
//  out_ready     in   1        consumer accepts when out_valid && out_ready
//  seed_err      out  1        1-cycle pulse: seed_in was zero, SEED substituted
//  busy_warmup   out  1        1 while in WARMUP
// BEHAVIOUR
//  Step: fb = ^(state & TAPS); state <= {state[LFSR_W-2:0], fb}. Word advance = STEPS steps.
//  Reset (rst_n=0 at edge): state=SEED; out_data=0; out_valid=0; seed_err=0;
//   FSM=WARMUP with cnt=WARMUP_CYCLES if WARMUP_CYCLES>0, else FSM=RUN; busy_warmup follows FSM.
//  Priority per edge: rst_n low > seed_load > warm-up/generation.
//  FSM WARMUP: each en=1 cycle: state advances 1 step, cnt-=1; cnt 1->0 transition -> RUN.
//   out_valid stays 0. en=0: hold everything.
//  FSM RUN: slot_free = !out_valid || out_ready.
//   en && slot_free: state <= STEPS-advanced state; out_data <= its [OUT_W-1:0]; out_valid<=1.
//   !en && out_valid && out_ready: out_valid<=0, state held.
//   !slot_free: state, out_data held stable (no word dropped, none generated).
//  Latency: one cycle from slot_free&&en to new out_valid/out_data; sustains 1 word/cycle with
//   out_ready tied high.
//  seed_load (any state): state <= (seed_in==0) ? SEED : seed_in; seed_err <= (seed_in==0);
//   out_valid<=0 (pending word discarded even if out_ready same cycle); FSM -> WARMUP with
//   cnt=WARMUP_CYCLES, or RUN if WARMUP_CYCLES==0. No shift on the load cycle.
//  seed_err is 0 on all cycles except the one following a zero-seed load.
//  Lockup guard: if state==0 ever observed in RUN/WARMUP (only via bad TAPS), reload SEED and
//   pulse seed_err; no word emitted that cycle.
//  Reset mid-operation: behaves exactly as power-up reset; pending word lost.
// TESTING
//  T1 defaults, rst_n low 2 cycles, then en=1,out_ready=1 -> first edge: out_valid=1,
//     out_data=4'h4 (state 32'h55555554); following words match golden LFSR model each cycle.
//  T2 out_ready=0 for 5 cycles after out_valid -> out_data stays 4'h4, state frozen;
//     raise out_ready -> next word = model step 2, no skip.
//  T3 seed_load with seed_in=0 -> seed_err=1 for one cycle, state=32'hAAAAAAAA, out_valid=0,
//     next word again 4'h4.
//  T4 WARMUP_CYCLES=3, reset, en=1 -> busy_warmup=1 for 3 cycles, out_valid=0; first word =
//     model state after 4 steps; toggling en=0 mid-warm-up extends warm-up by same count.
//  T5 STEPS=4, OUT_W=8, seed 32'h00000001 -> each word equals model advanced 4 steps,
//     low byte; compare 1000 words.
//  T6 seed_load asserted same cycle as out_valid&&out_ready and as rst_n=0 -> reset wins;
//     separately seed_load vs handshake -> load wins, out_valid=0 next cycle.

Source files
------------

// File: rtl/lfsr_rng_gen.sv
// Parametrised Fibonacci-LFSR random-word generator with seed load, warm-up discard,
// multi-step advance per word and a valid/ready output handshake.
module lfsr_rng_gen #(
    parameter int unsigned          LFSR_W        = 32,
    parameter logic [LFSR_W-1:0]    TAPS          = 32'hB89ADA1C,
    parameter logic [LFSR_W-1:0]    SEED          = 32'hAAAAAAAA,
    parameter int unsigned          OUT_W         = 4,
    parameter int unsigned          STEPS         = 1,
    parameter int unsigned          WARMUP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              seed_err,
    output logic              busy_warmup
);

    localparam int unsigned CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES);

    typedef enum logic {
        S_WARMUP,
        S_RUN
    } state_e;

    localparam state_e START = (WARMUP_CYCLES > 0) ? S_WARMUP : S_RUN;

    state_e            fsm_q, fsm_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [LFSR_W-1:0] adv;
    logic              slot_free;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAPS)};
    endfunction

    always_comb begin
        adv = lfsr_q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            adv = lfsr_step(adv);
        end
    end

    assign slot_free = !valid_q || out_ready;

    always_comb begin
        fsm_d   = fsm_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        if (seed_load) begin
            // A pending word is dropped on load, even if it is being accepted this cycle.
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            err_d   = (seed_in == '0);
            valid_d = 1'b0;
            fsm_d   = START;
            cnt_d   = CNT_INIT;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED;
            err_d  = 1'b1;
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
        end else begin
            case (fsm_q)
                S_WARMUP: begin
                    if (en) begin
                        lfsr_d = lfsr_step(lfsr_q);
                        cnt_d  = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            fsm_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (en && slot_free) begin
                        lfsr_d  = adv;
                        data_d  = adv[OUT_W-1:0];
                        valid_d = 1'b1;
                    end else if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: fsm_d = START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= START;
            lfsr_q  <= SEED;
            cnt_q   <= CNT_INIT;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign seed_err    = err_q;
    assign busy_warmup = (fsm_q == S_WARMUP);

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Scoreboard bench for lfsr_rng_gen: dut0 uses defaults, dut1 uses OUT_W=8, STEPS=4, WARMUP_CYCLES=3.
module tb_lfsr_rng_gen;

    localparam logic [31:0] SEED_C = 32'hAAAAAAAA;
    localparam logic [31:0] TAPS_C = 32'hB89ADA1C;

    logic             clk = 1'b0;
    logic [1:0]       rst_n = '0, en = '0, ld = '0, rdy = '0;
    logic [1:0][31:0] sin = '0;
    logic [1:0]       ov, serr, busy;
    logic [3:0]       od0;
    logic [7:0]       od1;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [31:0] ms[2];
    bit          armed[2] = '{0, 0};
    int          total = 0, bad = 0, words1 = 0, nb = 0;
    logic [7:0]  mon_w, hold;
    logic [4:0]  pat = 5'b11001;

    logic [1:0]       p_rst = '0, p_ld = '0, p_en = '0, p_rdy = '0, p_ov = '0, p_busy = '0;
    logic [1:0][31:0] p_sin = '0;
    logic [1:0][7:0]  p_od = '0;

    always #5 clk = ~clk;

    lfsr_rng_gen #(.OUT_W(4), .STEPS(1), .WARMUP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .seed_load(ld[0]), .seed_in(sin[0]),
        .out_data(od0), .out_valid(ov[0]), .out_ready(rdy[0]), .seed_err(serr[0]),
        .busy_warmup(busy[0])
    );

    lfsr_rng_gen #(.OUT_W(8), .STEPS(4), .WARMUP_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .seed_load(ld[1]), .seed_in(sin[1]),
        .out_data(od1), .out_valid(ov[1]), .out_ready(rdy[1]), .seed_err(serr[1]),
        .busy_warmup(busy[1])
    );

    function automatic int warm_of(int d);  return (d != 0) ? 3 : 0; endfunction
    function automatic int steps_of(int d); return (d != 0) ? 4 : 1; endfunction
    function automatic logic [31:0] mask_of(int d); return (d != 0) ? 32'hFF : 32'hF; endfunction
    function automatic logic [7:0] od_of(int d); return (d != 0) ? od1 : {4'h0, od0}; endfunction
    function automatic int qsize(int d); return (d != 0) ? q1.size() : q0.size(); endfunction

    // Reference step: parity of tapped bits by counting, shifted in at the bottom.
    function automatic logic [31:0] lstep(input logic [31:0] s);
        logic [31:0] t;
        int ones;
        t = TAPS_C;
        ones = 0;
        for (int i = 0; i < 32; i++) if (s[i] && t[i]) ones++;
        return (s << 1) | 32'(ones % 2);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic topup(input int d);
        logic [7:0] w;
        if (!armed[d]) return;
        while (qsize(d) < 8) begin
            for (int k = 0; k < steps_of(d); k++) ms[d] = lstep(ms[d]);
            w = 8'(ms[d] & mask_of(d));
            if (d != 0) q1.push_back(w);
            else q0.push_back(w);
        end
    endtask

    task automatic refill(input int d, input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        for (int k = 0; k < warm_of(d); k++) s = lstep(s);
        ms[d] = s;
        if (d != 0) q1.delete();
        else q0.delete();
        armed[d] = 1'b1;
        topup(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        topup(0);
        topup(1);
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        tick();
        tick();
        refill(d, SEED_C);
        rst_n[d] = 1'b1;
    endtask

    task automatic do_load(input int d, input logic [31:0] seed);
        ld[d]  = 1'b1;
        sin[d] = seed;
        tick();
        ld[d] = 1'b0;
        refill(d, (seed == 32'h0) ? SEED_C : seed);
    endtask

    task automatic rand_phase(input int d, input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 199);
            en[d]  = ($urandom_range(0, 7) != 0);
            rdy[d] = ($urandom_range(0, 2) != 0);
            if (r == 0) do_reset(d);
            else if (r < 5) do_load(d, ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom));
            else tick();
        end
    endtask

    // Monitor: protocol rules against last cycle's inputs, and accepted words against the queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!p_rst[d]) begin
                chk("rst_valid", d, ov[d], 0);
                chk("rst_data", d, od_of(d), 0);
                chk("rst_err", d, serr[d], 0);
                chk("rst_busy", d, busy[d], (warm_of(d) > 0) ? 1 : 0);
            end else if (p_ld[d]) begin
                chk("load_valid", d, ov[d], 0);
                chk("load_err", d, serr[d], (p_sin[d] == 32'h0) ? 1 : 0);
            end else begin
                chk("err_idle", d, serr[d], 0);
                if (p_busy[d]) begin
                    chk("warm_valid", d, ov[d], 0);
                end else if (p_ov[d] && !p_rdy[d]) begin
                    chk("stall_valid", d, ov[d], 1);
                    chk("stall_data", d, od_of(d), p_od[d]);
                end else if (p_en[d]) begin
                    chk("gen_valid", d, ov[d], 1);
                end else if (p_ov[d] && p_rdy[d]) begin
                    chk("drain_valid", d, ov[d], 0);
                end
            end
            if (ov[d] && rdy[d]) begin
                if (qsize(d) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word dut%0d: got %h expected none queued", d, od_of(d));
                end else begin
                    mon_w = (d != 0) ? q1.pop_front() : q0.pop_front();
                    chk("word", d, od_of(d), mon_w);
                    if (d != 0) words1++;
                end
            end
            p_rst[d] = rst_n[d]; p_ld[d] = ld[d]; p_en[d] = en[d]; p_rdy[d] = rdy[d];
            p_ov[d] = ov[d]; p_busy[d] = busy[d]; p_sin[d] = sin[d]; p_od[d] = od_of(d);
        end
    end

    initial begin
        tick();
        tick();
        // dut0: first word from SEED 32'hAAAAAAAA is state 32'h55555554 -> 4'h4
        en[0] = 1'b1;
        rdy[0] = 1'b1;
        refill(0, SEED_C);
        rst_n[0] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t1_valid", 0, ov[0], 1);
        chk("t1_data", 0, od0, 4'h4);
        repeat (20) tick();

        rdy[0] = 1'b0;
        @(negedge clk);
        hold = od_of(0);
        chk("t2_valid", 0, ov[0], 1);
        repeat (5) tick();
        @(negedge clk);
        chk("t2_hold", 0, od_of(0), hold);
        tick();
        rdy[0] = 1'b1;
        repeat (10) tick();

        do_load(0, 32'h0);
        @(negedge clk);
        chk("t3_err", 0, serr[0], 1);
        chk("t3_valid", 0, ov[0], 0);
        tick();
        @(negedge clk);
        chk("t3_err_clear", 0, serr[0], 0);
        chk("t3_word", 0, od0, 4'h4);

        repeat (5) tick();
        ld[0] = 1'b1;
        sin[0] = 32'h12345679;
        rst_n[0] = 1'b0;
        tick();
        ld[0] = 1'b0;
        tick();
        refill(0, SEED_C);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("t6_err", 0, serr[0], 0);
        chk("t6_valid", 0, ov[0], 0);
        tick();
        @(negedge clk);
        chk("t6_word", 0, od0, 4'h4);
        tick();
        rand_phase(0, 800);
        en[0] = 1'b0;

        // dut1: warm-up length stretched by en=0 cycles (pattern 1,0,0,1,1)
        rdy[1] = 1'b1;
        do_reset(1);
        en[1] = pat[0];
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy[1]) break;
            nb++;
            tick();
            en[1] = (i + 1 < 5) ? pat[i+1] : 1'b1;
        end
        chk("t4_busy_cycles", 1, 32'(nb), 5);
        tick();
        @(negedge clk);
        chk("t4_first_valid", 1, ov[1], 1);
        tick();

        do_load(1, 32'h1);
        words1 = 0;
        repeat (1010) tick();
        chk("t5_word_count", 1, (words1 >= 1000) ? 1 : 0, 1);
        rand_phase(1, 600);
        en = '0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
